ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

D/E pipeline register and operand-forwarding stage directly upstream of the ALU. Captures decoded instruction fields each cycle, honours stall and flush from the hazard unit, and drives the ALU's `SrcA`, `SrcB` and `ALUControl` inputs through M- and W-stage bypass muxes. It also supplies the forwarded store data and the control bits that travel on to the M stage.

## Interface
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register-address width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_e`  in  1  hold E register contents.
- `flush_e`  in  1  load a bubble into E.
- `valid_d`  in  1  D-stage instruction valid.
- `pc_d`, `rs1_data_d`, `rs2_data_d`, `imm_ext_d`  in  XLEN  decoded values.
- `rs1_d`, `rs2_d`, `rd_d`  in  RA_W  register addresses.
- `alu_control_d`  in  4  ALU operation code.
- `src_a_sel_d`  in  2  SrcA select: 00 rs1, 01 pc, 10/11 zero.
- `src_b_sel_d`  in  1  SrcB select: 0 rs2, 1 imm.
- `reg_write_d`, `mem_write_d`  in  1  write enables.
- `result_src_d`  in  2  result mux select for W.
- `rd_m`, `rd_w`  in  RA_W  M/W destination registers.
- `reg_write_m`, `reg_write_w`  in  1  M/W write enables.
- `alu_result_m`, `result_w`  in  XLEN  M/W forward values.
- `src_a_e`, `src_b_e`  out  XLEN  ALU operands.
- `alu_control_e`  out  4  ALU operation code.
- `store_data_e`  out  XLEN  forwarded rs2 value.
- `pc_e`  out  XLEN; `rs1_e`, `rs2_e`, `rd_e`  out  RA_W.
- `valid_e`, `reg_write_e`, `mem_write_e`  out  1; `result_src_e`  out  2.

## Operation
- The E register updates on the rising `clk` edge. Priority is `rst` > `flush_e` > `stall_e` > load.
- Reset and bubble state: every registered field is 0. This gives `valid_e`=0, `reg_write_e`=0, `mem_write_e`=0, `alu_control_e`=0000 (ADD), `rd_e`=0.
- Flush asserted together with stall: flush wins and a bubble is loaded.
- Load: all `*_d` fields are captured into E. `valid_e` takes `valid_d`. When `valid_d`=0, the register loads a bubble instead.
- Forwarding is evaluated per operand, for rs1 and rs2 independently:
  - M hit: `reg_write_m` && `rd_m`≠0 && `rd_m`==`rsX_e`; selects `alu_result_m`.
  - Otherwise W hit: the same test against `rd_w`/`reg_write_w`; selects `result_w`.
  - Otherwise: the registered `rsX_data_e`.
  - M always beats W. Register x0 is never forwarded.
- Operand refresh during stall: while `stall_e`=1 and not flushed, `rs1_data_e`/`rs2_data_e` reload their own forwarded value each cycle. This ensures a producer that retires from W during the stall is not lost. All other fields hold.
- Output muxing:
  - `src_a_e` = fwd_rs1, `pc_e`, or 0 per `src_a_sel_e`.
  - `src_b_e` = fwd_rs2 or `imm_ext_e` per `src_b_sel_e`.
  - `store_data_e` = fwd_rs2 always.
- No arithmetic is performed here. All values pass through at full XLEN without truncation.

## Timing
- D→E latency is 1 cycle. Outputs are valid from the clock edge after capture.
- Forward paths are combinational, M/W inputs → `src_a_e`/`src_b_e`/`store_data_e` in the same cycle.
- `rst` clears the E register immediately and asynchronously. Reset release takes effect at the next edge.
- A stall of N cycles holds control fields for N edges. Operands refresh every cycle of the stall.
- A bubble flows as a NOP: an ADD of 0+0 with no write side effects.

## Structure
- Shared package, reused by the ALU decoder and the ALU:
  - ALU code constants: ADD 0000, SUB 0001, AND 0010, OR 0011, PASSB 0100, SLT 0101, XOR 0110, SRL 0111, SLL 1000, SRA 1001, SLTU 1010.
  - SrcA select constants.
  - Forward-select enum: NONE/M/W.
- One sub-module: `operand_forward`, a comparator plus 3:1 mux. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset mid-run with E holding ADD rd=5 → outputs zero immediately; `valid_e`=0, `reg_write_e`=0.
- Load `alu_control_d`=0001, rs1=3, rs2=4, data 10/7, no hazards → next cycle `src_a_e`=10, `src_b_e`=7, `alu_control_e`=0001.
- `rd_m`=`rd_w`=3, both writing, `alu_result_m`=0xAA, `result_w`=0xBB, `rs1_e`=3 → `src_a_e`=0xAA. Set `rd_m`=0 → `src_a_e`=0xBB. `rs1_e`=0 with `rd_w`=0 → no forward.
- Stall 2 cycles while `rd_w`=4 writes 0x55 in the first stall cycle, `rs2_e`=4 → after the stall `store_data_e`=0x55 with no hazard active.
- `flush_e`=`stall_e`=1 → bubble loaded; `mem_write_e`=0, `alu_control_e`=0000.
- `src_a_sel_d`=01, `pc_d`=0x100, `src_b_sel_d`=1, imm=0x20 → `src_a_e`=0x100, `src_b_e`=0x20. `src_a_sel_d`=10 → `src_a_e`=0.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, SrcA
// select encodings and the operand-forward select enum.
package ex_operand_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_PASSB = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_W    = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_forward.sv
// Per-operand bypass: M-stage hit beats W-stage hit; x0 is never forwarded.
module operand_forward
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [RA_W-1:0] rd_m_i,
    input  logic            reg_write_m_i,
    input  logic [XLEN-1:0] alu_result_m_i,
    input  logic [RA_W-1:0] rd_w_i,
    input  logic            reg_write_w_i,
    input  logic [XLEN-1:0] result_w_i,
    output logic [XLEN-1:0] fwd_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_NONE;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel = FWD_W;
        end
    end

    always_comb begin
        case (sel)
            FWD_M:   fwd_o = alu_result_m_i;
            FWD_W:   fwd_o = result_w_i;
            default: fwd_o = rs_data_i;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// D/E pipeline register with M/W operand bypass feeding the ALU inputs,
// store data and the control bits that continue to the M stage.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] rs1_data_d,
    input  logic [XLEN-1:0] rs2_data_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [RA_W-1:0] rs1_d,
    input  logic [RA_W-1:0] rs2_d,
    input  logic [RA_W-1:0] rd_d,
    input  logic [3:0]      alu_control_d,
    input  logic [1:0]      src_a_sel_d,
    input  logic            src_b_sel_d,
    input  logic            reg_write_d,
    input  logic            mem_write_d,
    input  logic [1:0]      result_src_d,
    input  logic [RA_W-1:0] rd_m,
    input  logic [RA_W-1:0] rd_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] src_a_e,
    output logic [XLEN-1:0] src_b_e,
    output logic [3:0]      alu_control_e,
    output logic [XLEN-1:0] store_data_e,
    output logic [XLEN-1:0] pc_e,
    output logic [RA_W-1:0] rs1_e,
    output logic [RA_W-1:0] rs2_e,
    output logic [RA_W-1:0] rd_e,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic [1:0]      result_src_e
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [3:0]      alu_control;
        logic [1:0]      src_a_sel;
        logic            src_b_sel;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } e_reg_t;

    e_reg_t          e_q;
    e_reg_t          e_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_i          (e_q.rs1),
        .rs_data_i     (e_q.rs1_data),
        .rd_m_i        (rd_m),
        .reg_write_m_i (reg_write_m),
        .alu_result_m_i(alu_result_m),
        .rd_w_i        (rd_w),
        .reg_write_w_i (reg_write_w),
        .result_w_i    (result_w),
        .fwd_o         (fwd_rs1)
    );

    operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_i          (e_q.rs2),
        .rs_data_i     (e_q.rs2_data),
        .rd_m_i        (rd_m),
        .reg_write_m_i (reg_write_m),
        .alu_result_m_i(alu_result_m),
        .rd_w_i        (rd_w),
        .reg_write_w_i (reg_write_w),
        .result_w_i    (result_w),
        .fwd_o         (fwd_rs2)
    );

    always_comb begin
        e_d = e_q;
        if (flush_e) begin
            e_d = '0;
        end else if (stall_e) begin
            // Operands re-capture their bypassed value so a W producer retiring mid-stall is kept.
            e_d.rs1_data = fwd_rs1;
            e_d.rs2_data = fwd_rs2;
        end else if (valid_d) begin
            e_d.valid       = 1'b1;
            e_d.pc          = pc_d;
            e_d.rs1_data    = rs1_data_d;
            e_d.rs2_data    = rs2_data_d;
            e_d.imm         = imm_ext_d;
            e_d.rs1         = rs1_d;
            e_d.rs2         = rs2_d;
            e_d.rd          = rd_d;
            e_d.alu_control = alu_control_d;
            e_d.src_a_sel   = src_a_sel_d;
            e_d.src_b_sel   = src_b_sel_d;
            e_d.reg_write   = reg_write_d;
            e_d.mem_write   = mem_write_d;
            e_d.result_src  = result_src_d;
        end else begin
            e_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    always_comb begin
        case (e_q.src_a_sel)
            SRCA_RS1: src_a_e = fwd_rs1;
            SRCA_PC:  src_a_e = e_q.pc;
            default:  src_a_e = '0;
        endcase
    end

    assign src_b_e       = e_q.src_b_sel ? e_q.imm : fwd_rs2;
    assign store_data_e  = fwd_rs2;
    assign alu_control_e = e_q.alu_control;
    assign pc_e          = e_q.pc;
    assign rs1_e         = e_q.rs1;
    assign rs2_e         = e_q.rs2;
    assign rd_e          = e_q.rd;
    assign valid_e       = e_q.valid;
    assign reg_write_e   = e_q.reg_write;
    assign mem_write_e   = e_q.mem_write;
    assign result_src_e  = e_q.result_src;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for the D/E register and bypass stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] pc_d, rs1_data_d, rs2_data_d, imm_ext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [3:0]  alu_control_d;
    logic [1:0]  src_a_sel_d;
    logic        src_b_sel_d, reg_write_d, mem_write_d;
    logic [1:0]  result_src_d;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [31:0] alu_result_m, result_w;
    logic [31:0] src_a_e, src_b_e, store_data_e, pc_e;
    logic [3:0]  alu_control_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        valid_e, reg_write_e, mem_write_e;
    logic [1:0]  result_src_e;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_ext_d(imm_ext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
        .src_a_sel_d(src_a_sel_d), .src_b_sel_d(src_b_sel_d), .reg_write_d(reg_write_d),
        .mem_write_d(mem_write_d), .result_src_d(result_src_d), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .alu_result_m(alu_result_m),
        .result_w(result_w), .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e),
        .store_data_e(store_data_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .result_src_e(result_src_e)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_e = 0; flush_e = 0; valid_d = 0;
        pc_d = '0; rs1_data_d = '0; rs2_data_d = '0; imm_ext_d = '0;
        rs1_d = '0; rs2_d = '0; rd_d = '0; alu_control_d = '0;
        src_a_sel_d = '0; src_b_sel_d = 0; reg_write_d = 0; mem_write_d = 0; result_src_d = '0;
        rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
        alu_result_m = '0; result_w = '0;
    endtask

    task automatic test_reset();
        // Load ADD rd=5, then reset asynchronously mid-cycle.
        clear_inputs();
        valid_d = 1; rd_d = 5'd5; reg_write_d = 1; alu_control_d = 4'b0000;
        rs1_d = 5'd1; rs1_data_d = 32'h1234; pc_d = 32'h40;
        tick();
        checks++;
        if (rd_e !== 5'd5 || valid_e !== 1'b1) begin
            errors++; $display("FAIL reset_preload rd_e=%0d valid_e=%0b required rd_e=5 valid_e=1", rd_e, valid_e);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || rd_e !== 5'd0 || pc_e !== 32'h0 || src_a_e !== 32'h0) begin
            errors++;
            $display("FAIL async_reset valid=%0b rw=%0b rd=%0d pc=%h srca=%h required all zero",
                     valid_e, reg_write_e, rd_e, pc_e, src_a_e);
        end
        tick();
        rst = 0;
        clear_inputs();
        tick();
        checks++;
        if (valid_e !== 1'b0 || alu_control_e !== 4'b0000 || mem_write_e !== 1'b0) begin
            errors++; $display("FAIL reset_release valid=%0b alu=%b mw=%0b required 0/0000/0", valid_e, alu_control_e, mem_write_e);
        end
    endtask

    task automatic test_load();
        clear_inputs();
        valid_d = 1; alu_control_d = 4'b0001; rs1_d = 5'd3; rs2_d = 5'd4;
        rs1_data_d = 32'd10; rs2_data_d = 32'd7; rd_d = 5'd9; reg_write_d = 1; result_src_d = 2'b01;
        tick();
        checks++;
        if (src_a_e !== 32'd10 || src_b_e !== 32'd7 || alu_control_e !== 4'b0001) begin
            errors++; $display("FAIL load_sub srca=%0d srcb=%0d alu=%b required 10/7/0001", src_a_e, src_b_e, alu_control_e);
        end
        checks++;
        if (valid_e !== 1'b1 || rd_e !== 5'd9 || reg_write_e !== 1'b1 || result_src_e !== 2'b01 || store_data_e !== 32'd7) begin
            errors++; $display("FAIL load_ctrl valid=%0b rd=%0d rw=%0b rs=%b sd=%0d required 1/9/1/01/7",
                               valid_e, rd_e, reg_write_e, result_src_e, store_data_e);
        end
    endtask

    task automatic test_forward();
        // E holds rs1=3, rs2=4 from test_load; D side idles with a bubble.
        stall_e = 1;
        rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1; reg_write_w = 1;
        alu_result_m = 32'hAA; result_w = 32'hBB;
        #1;
        checks++;
        if (src_a_e !== 32'hAA) begin
            errors++; $display("FAIL fwd_m_beats_w srca=%h required 000000aa", src_a_e);
        end
        checks++;
        if (src_b_e !== 32'd7) begin
            errors++; $display("FAIL fwd_rs2_no_hit srcb=%h required 00000007", src_b_e);
        end
        rd_m = 5'd0;
        #1;
        checks++;
        if (src_a_e !== 32'hBB) begin
            errors++; $display("FAIL fwd_w srca=%h required 000000bb", src_a_e);
        end
        rd_m = 5'd4;
        #1;
        checks++;
        if (store_data_e !== 32'hAA || src_a_e !== 32'hBB) begin
            errors++; $display("FAIL fwd_independent sd=%h srca=%h required 000000aa/000000bb", store_data_e, src_a_e);
        end
        // rs1=0 must never take a bypass, even against an rd=0 writer.
        clear_inputs();
        valid_d = 1; rs1_d = 5'd0; rs1_data_d = 32'h11; rs2_d = 5'd2; rs2_data_d = 32'h22;
        tick();
        valid_d = 0;
        rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1; reg_write_w = 1;
        alu_result_m = 32'hAA; result_w = 32'hBB; stall_e = 1;
        #1;
        checks++;
        if (src_a_e !== 32'h11) begin
            errors++; $display("FAIL fwd_x0 srca=%h required 00000011", src_a_e);
        end
    endtask

    task automatic test_stall_refresh();
        clear_inputs();
        valid_d = 1; rs2_d = 5'd4; rs2_data_d = 32'h7; rs1_d = 5'd6; rs1_data_d = 32'h66;
        alu_control_d = 4'b0010; rd_d = 5'd8; mem_write_d = 1;
        tick();
        // First stall cycle: W retires rd=4 with 0x55.
        stall_e = 1; alu_control_d = 4'b0110; rd_d = 5'd12; rs2_data_d = 32'h99;
        rd_w = 5'd4; reg_write_w = 1; result_w = 32'h55;
        tick();
        reg_write_w = 0; rd_w = 5'd0; result_w = 32'h0;
        tick();
        stall_e = 0; valid_d = 0;
        #1;
        checks++;
        if (store_data_e !== 32'h55) begin
            errors++; $display("FAIL stall_refresh sd=%h required 00000055", store_data_e);
        end
        checks++;
        if (alu_control_e !== 4'b0010 || rd_e !== 5'd8 || src_a_e !== 32'h66 || mem_write_e !== 1'b1) begin
            errors++; $display("FAIL stall_hold alu=%b rd=%0d srca=%h mw=%0b required 0010/8/00000066/1",
                               alu_control_e, rd_e, src_a_e, mem_write_e);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        valid_d = 1; mem_write_d = 1; reg_write_d = 1; alu_control_d = 4'b0101; rd_d = 5'd7;
        rs1_data_d = 32'h3; rs2_data_d = 32'h4; rs1_d = 5'd1; rs2_d = 5'd2;
        tick();
        flush_e = 1; stall_e = 1;
        tick();
        checks++;
        if (mem_write_e !== 1'b0 || alu_control_e !== 4'b0000 || valid_e !== 1'b0 || reg_write_e !== 1'b0
            || src_a_e !== 32'h0 || src_b_e !== 32'h0 || rd_e !== 5'd0) begin
            errors++; $display("FAIL flush_stall mw=%0b alu=%b valid=%0b rw=%0b srca=%h srcb=%h rd=%0d required bubble",
                               mem_write_e, alu_control_e, valid_e, reg_write_e, src_a_e, src_b_e, rd_e);
        end
        // An invalid D instruction also loads a bubble.
        flush_e = 0; stall_e = 0;
        tick();
        checks++;
        if (valid_e !== 1'b1 || mem_write_e !== 1'b1) begin
            errors++; $display("FAIL flush_reload valid=%0b mw=%0b required 1/1", valid_e, mem_write_e);
        end
        valid_d = 0;
        tick();
        checks++;
        if (valid_e !== 1'b0 || mem_write_e !== 1'b0 || reg_write_e !== 1'b0 || alu_control_e !== 4'b0000) begin
            errors++; $display("FAIL invalid_bubble valid=%0b mw=%0b rw=%0b alu=%b required 0/0/0/0000",
                               valid_e, mem_write_e, reg_write_e, alu_control_e);
        end
    endtask

    task automatic test_src_select();
        clear_inputs();
        valid_d = 1; src_a_sel_d = 2'b01; pc_d = 32'h100; src_b_sel_d = 1; imm_ext_d = 32'h20;
        rs1_data_d = 32'h5; rs2_data_d = 32'h6;
        tick();
        checks++;
        if (src_a_e !== 32'h100 || src_b_e !== 32'h20 || store_data_e !== 32'h6) begin
            errors++; $display("FAIL sel_pc_imm srca=%h srcb=%h sd=%h required 00000100/00000020/00000006",
                               src_a_e, src_b_e, store_data_e);
        end
        src_a_sel_d = 2'b10;
        tick();
        checks++;
        if (src_a_e !== 32'h0) begin
            errors++; $display("FAIL sel_zero10 srca=%h required 00000000", src_a_e);
        end
        src_a_sel_d = 2'b11; pc_d = 32'hFFFF_FFFC; imm_ext_d = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (src_a_e !== 32'h0 || src_b_e !== 32'hDEAD_BEEF || pc_e !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL sel_zero11_fullwidth srca=%h srcb=%h pc=%h required 00000000/deadbeef/fffffffc",
                               src_a_e, src_b_e, pc_e);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #1;
        checks++;
        if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0 || alu_control_e !== 4'b0000 || rd_e !== 5'd0) begin
            errors++; $display("FAIL initial_reset valid=%0b rw=%0b mw=%0b alu=%b rd=%0d required zero",
                               valid_e, reg_write_e, mem_write_e, alu_control_e, rd_e);
        end
        tick();
        rst = 0;
        tick();
        test_reset();
        test_load();
        test_forward();
        test_stall_refresh();
        test_flush();
        test_src_select();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
